// File: rtl/cla_seq_divider.sv
// Multi-cycle unsigned restoring divider with a start/busy/done handshake.
// Each iteration does one trial subtraction R - D as R + ~D + 1 on a WIDTH+1 bit CLA-style adder.
module cla_seq_divider #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    // Trial subtraction: shifted R (WIDTH+1 bits so its msb is never lost) plus ~D plus 1
    logic [WIDTH:0]   sh, op_b, p, g;
    logic [WIDTH+1:0] c;
    logic [WIDTH-1:0] sum;
    logic             no_borrow;

    always_comb begin
        sh   = {r_q, q_q[WIDTH-1]};
        op_b = ~{1'b0, d_q};
        p    = sh ^ op_b;
        g    = sh & op_b;
        c    = '0;
        c[0] = 1'b1;
        for (int i = 0; i <= WIDTH; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        sum = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i] = p[i] ^ c[i];
        end
        no_borrow = c[WIDTH+1];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        d_d     = d_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    if (divisor != '0) begin
                        state_d = RUN;
                        q_d     = dividend;
                        d_d     = divisor;
                        r_d     = '0;
                        cnt_d   = '0;
                    end else begin
                        state_d = DONE;
                        quo_d   = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                    end
                end
            end
            RUN: begin
                // Without a borrow the trial result always fits WIDTH bits since it is < D
                r_d   = no_borrow ? sum : sh[WIDTH-1:0];
                q_d   = {q_q[WIDTH-2:0], no_borrow};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    quo_d   = q_d;
                    rem_d   = r_d;
                    dbz_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            d_q     <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            d_q     <= d_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule
